// File: rtl/flash_page_buf.sv
// Flash-side page buffer: captures one encoded page from the ECC controller, then
// plays it back one byte per clock, optionally corrupting up to two byte addresses.
module flash_page_buf #(
  parameter int PAGE_BYTES = 528,
  parameter int AW         = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  input  logic [7:0]    wr_data,
  input  logic          rd_start,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          page_done,
  output logic          wr_ovf,
  input  logic [1:0]    err_en,
  input  logic [AW-1:0] err_adrs0,
  input  logic [AW-1:0] err_adrs1,
  input  logic [7:0]    err_xor
);

  localparam logic [AW-1:0] LAST     = AW'(PAGE_BYTES - 1);
  localparam logic [AW-1:0] PAGE_END = AW'(PAGE_BYTES);

  typedef enum logic [1:0] {IDLE, PROG, READ} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [1:0]    err_en_reg;
  logic [AW-1:0] err_adrs_reg [2];
  logic [7:0]    err_xor_reg;
  logic [7:0]    mem [PAGE_BYTES];

  logic          wr_en, wr_last, rd_load, rd_end, start_rd;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [AW-1:0] adrs_in   [2];
  logic [AW-1:0] slot_adrs [2];
  logic [1:0]    slot_en, slot_hit;
  logic [7:0]    slot_xor, rd_mask;

  always_comb begin
    state_next = state_reg;
    wr_en      = 1'b0;
    wr_addr    = wr_ptr_reg;
    rd_load    = 1'b0;
    rd_addr    = rd_ptr_reg;
    start_rd   = 1'b0;
    case (state_reg)
      IDLE: begin
        // A write arriving together with rd_start takes priority.
        if (wr_valid) begin
          wr_en      = 1'b1;
          wr_addr    = '0;
          state_next = PROG;
        end else if (rd_start) begin
          start_rd   = 1'b1;
          rd_load    = 1'b1;
          rd_addr    = '0;
          state_next = READ;
        end
      end
      PROG: begin
        if (wr_valid) begin
          wr_en = 1'b1;
          if (wr_ptr_reg == LAST) state_next = IDLE;
        end
      end
      READ: begin
        if (rd_ptr_reg == PAGE_END) state_next = IDLE;
        else                        rd_load    = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign wr_last  = wr_en && (state_reg == PROG) && (wr_ptr_reg == LAST);
  assign rd_end   = (state_reg == READ) && (rd_ptr_reg == PAGE_END);
  assign busy     = (state_reg != IDLE);

  // The first byte is presented at the start edge, before the latches are loaded.
  assign adrs_in[0] = err_adrs0;
  assign adrs_in[1] = err_adrs1;
  assign slot_en    = start_rd ? err_en  : err_en_reg;
  assign slot_xor   = start_rd ? err_xor : err_xor_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      assign slot_adrs[gi] = start_rd ? adrs_in[gi] : err_adrs_reg[gi];
      assign slot_hit[gi]  = slot_en[gi] && (slot_adrs[gi] == rd_addr) &&
                             (slot_adrs[gi] < PAGE_END);
    end
  endgenerate

  assign rd_mask = (|slot_hit) ? slot_xor : 8'h00;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      rd_data         <= 8'h00;
      rd_valid        <= 1'b0;
      page_done       <= 1'b0;
      wr_ovf          <= 1'b0;
      err_en_reg      <= 2'b00;
      err_adrs_reg[0] <= '0;
      err_adrs_reg[1] <= '0;
      err_xor_reg     <= 8'h00;
    end else begin
      page_done <= wr_last || rd_end;
      if (wr_en) wr_ptr_reg <= wr_last ? '0 : wr_addr + AW'(1);
      if (start_rd) begin
        err_en_reg      <= err_en;
        err_adrs_reg[0] <= err_adrs0;
        err_adrs_reg[1] <= err_adrs1;
        err_xor_reg     <= err_xor;
      end
      if (rd_load) begin
        rd_data    <= mem[rd_addr] ^ rd_mask;
        rd_ptr_reg <= rd_addr + AW'(1);
        rd_valid   <= 1'b1;
      end else if (rd_end) begin
        rd_ptr_reg <= '0;
        rd_valid   <= 1'b0;
      end
      if ((state_reg == READ) && wr_valid) wr_ovf <= 1'b1;
    end
  end

endmodule
